// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Input-side front end of the irrigation controller. Takes the raw board pins
// (two active-low buttons and two active-high level switches), synchronises
// them into the fast_clock domain, debounces each one independently and turns
// the clean button levels into one-cycle event pulses for the downstream FSMs.
//
// Parameters
//   DEBOUNCE_CYCLES    consecutive differing samples needed before a new level
//                      is accepted (>= 2)
//   LONG_PRESS_CYCLES  clean-press cycles on push before reset_request fires
//                      (>= 2)
//
// Ports
//   clock             fast_clock, all state updates on the rising edge
//   reset_pulse       asynchronous, active-high reset
//   fertilise_button  raw button, active-low, asynchronous to clock
//   push              raw button, active-low, asynchronous to clock
//   splinker_switch   raw switch, active-high, asynchronous
//   dripper_switch    raw switch, active-high, asynchronous
//   fertilise_push    one-cycle pulse per accepted press of fertilise_button
//   push_short        one-cycle pulse when push is released before the
//                     long-press threshold
//   reset_request     one-cycle pulse when push has been held for
//                     LONG_PRESS_CYCLES; it is only a request, whoever ORs it
//                     into reset_pulse must register it first
//   splinker_level    debounced splinker_switch
//   dripper_level     debounced dripper_switch
//   switch_conflict   registered splinker_level & dripper_level
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_pulse,
    input  logic fertilise_button,
    input  logic push,
    input  logic splinker_switch,
    input  logic dripper_switch,
    output logic fertilise_push,
    output logic push_short,
    output logic reset_request,
    output logic splinker_level,
    output logic dripper_level,
    output logic switch_conflict
);

    // Counter widths: the debounce counter only has to reach DEBOUNCE_CYCLES-1
    // and the hold counter only LONG_PRESS_CYCLES-1 before the FSM leaves HELD.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Channel indices into the packed per-channel vectors.
    localparam int CH_FERT   = 0;
    localparam int CH_PUSH   = 1;
    localparam int CH_SPLINK = 2;
    localparam int CH_DRIP   = 3;
    localparam int NUM_CH    = 4;

    // Buttons idle high (released), switches idle low.
    localparam logic [NUM_CH-1:0] IDLE_LEVELS = 4'b0011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LATCHED = 2'd2
    } push_state_t;

    logic [NUM_CH-1:0]           raw_in;
    logic [NUM_CH-1:0]           sync_meta;
    logic [NUM_CH-1:0]           sync_out;
    logic [NUM_CH-1:0]           stable;
    logic [NUM_CH-1:0][DB_W-1:0] db_cnt;
    logic [NUM_CH-1:0]           accept;

    logic                        fert_press;
    logic                        push_press;
    logic                        push_release;

    push_state_t                 push_state;
    logic [HOLD_W-1:0]           hold_cnt;

    assign raw_in[CH_FERT]   = fertilise_button;
    assign raw_in[CH_PUSH]   = push;
    assign raw_in[CH_SPLINK] = splinker_switch;
    assign raw_in[CH_DRIP]   = dripper_switch;

    // Two-flop synchroniser per pin, nothing between the flops so the first
    // stage has a full cycle to resolve metastability.
    always_ff @(posedge clock or posedge reset_pulse) begin
        if (reset_pulse) begin
            sync_meta <= IDLE_LEVELS;
            sync_out  <= IDLE_LEVELS;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

    // A channel flips on the edge where its counter has already seen
    // DEBOUNCE_CYCLES-1 differing samples and the current sample still differs.
    // Exposing this as a combinational strobe lets the pulse registers fire on
    // the same edge the stable value changes.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i] = (sync_out[i] != stable[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Per-channel debounce: any sample that agrees with the stable value
    // clears the counter, so a glitch shorter than the window leaves no trace.
    always_ff @(posedge clock or posedge reset_pulse) begin
        if (reset_pulse) begin
            stable <= IDLE_LEVELS;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_out[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_out[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Buttons are active-low: a press is the stable value going 1 -> 0,
    // a release is 0 -> 1.
    assign fert_press   = accept[CH_FERT] & ~sync_out[CH_FERT];
    assign push_press   = accept[CH_PUSH] & ~sync_out[CH_PUSH];
    assign push_release = accept[CH_PUSH] &  sync_out[CH_PUSH];

    // One pulse per accepted fertilise press; holding the button does not
    // repeat because only the 1 -> 0 transition produces a strobe.
    always_ff @(posedge clock or posedge reset_pulse) begin
        if (reset_pulse) begin
            fertilise_push <= 1'b0;
        end else begin
            fertilise_push <= fert_press;
        end
    end

    // Push FSM. HELD counts cycles since the clean press; reaching the
    // threshold wins over a release landing on the same edge, so that case
    // yields reset_request only and goes straight back to IDLE. LATCHED just
    // waits for the release so a long hold never also reports a short push.
    always_ff @(posedge clock or posedge reset_pulse) begin
        if (reset_pulse) begin
            push_state    <= IDLE;
            hold_cnt      <= '0;
            push_short    <= 1'b0;
            reset_request <= 1'b0;
        end else begin
            push_short    <= 1'b0;
            reset_request <= 1'b0;
            case (push_state)
                IDLE: begin
                    if (push_press) begin
                        push_state <= HELD;
                        hold_cnt   <= '0;
                    end
                end
                HELD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        reset_request <= 1'b1;
                        push_state    <= push_release ? IDLE : LATCHED;
                    end else if (push_release) begin
                        push_short <= 1'b1;
                        push_state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LATCHED: begin
                    if (push_release) begin
                        push_state <= IDLE;
                    end
                end
                default: begin
                    push_state <= IDLE;
                    hold_cnt   <= '0;
                end
            endcase
        end
    end

    // Switch levels come straight from the debounced registers; the conflict
    // flag is registered from them and therefore trails them by one cycle.
    assign splinker_level = stable[CH_SPLINK];
    assign dripper_level  = stable[CH_DRIP];

    always_ff @(posedge clock or posedge reset_pulse) begin
        if (reset_pulse) begin
            switch_conflict <= 1'b0;
        end else begin
            switch_conflict <= stable[CH_SPLINK] & stable[CH_DRIP];
        end
    end

endmodule
